// File: rtl/delay_signed_vprog.sv
// Programmable-depth, stallable delay line for LENGTH signed channels with a
// shared valid flag; depth is retunable at run time up to MAX_DELAY.
module delay_signed_vprog #(
    parameter int WIDTH         = 16,
    parameter int LENGTH        = 4,
    parameter int MAX_DELAY     = 16,
    parameter int DEFAULT_DELAY = 1,
    parameter int DW            = $clog2(MAX_DELAY + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] a [LENGTH],
    input  logic                    va,
    input  logic [DW-1:0]           delay,
    input  logic                    delay_ld,
    input  logic                    flush,
    output logic signed [WIDTH-1:0] c [LENGTH],
    output logic                    vc,
    output logic [DW-1:0]           cur_delay
);

    localparam logic [DW-1:0] MAX_D = DW'(MAX_DELAY);
    localparam logic [DW-1:0] DEF_D = DW'(DEFAULT_DELAY);

    logic signed [WIDTH-1:0] data [MAX_DELAY][LENGTH];
    logic [MAX_DELAY-1:0]    valid;
    logic [MAX_DELAY-1:0]    valid_nxt;
    logic [DW-1:0]           delay_clamped;

    always_comb begin
        if (delay == '0)
            delay_clamped = DW'(1);
        else if (delay > MAX_D)
            delay_clamped = MAX_D;
        else
            delay_clamped = delay;
    end

    // A load or flush kills everything already in flight, but the sample
    // entering on that same enabled edge keeps its valid bit.
    always_comb begin
        valid_nxt = valid;
        if (en) begin
            valid_nxt[0] = va;
            for (int unsigned k = 1; k < MAX_DELAY; k++)
                valid_nxt[k] = valid[k-1];
        end
        if (delay_ld || flush) begin
            for (int unsigned k = 1; k < MAX_DELAY; k++)
                valid_nxt[k] = 1'b0;
            if (!en)
                valid_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < MAX_DELAY; k++)
                for (int unsigned i = 0; i < LENGTH; i++)
                    data[k][i] <= '0;
            valid     <= '0;
            cur_delay <= DEF_D;
        end else begin
            if (en) begin
                for (int unsigned i = 0; i < LENGTH; i++)
                    data[0][i] <= a[i];
                for (int unsigned k = 1; k < MAX_DELAY; k++)
                    for (int unsigned i = 0; i < LENGTH; i++)
                        data[k][i] <= data[k-1][i];
            end
            valid <= valid_nxt;
            if (delay_ld)
                cur_delay <= delay_clamped;
        end
    end

    // Output tap is an unregistered mux; cur_delay is always 1..MAX_DELAY.
    always_comb begin
        vc = 1'b0;
        for (int unsigned i = 0; i < LENGTH; i++)
            c[i] = '0;
        for (int unsigned k = 0; k < MAX_DELAY; k++) begin
            if (cur_delay == DW'(k + 1)) begin
                vc = valid[k];
                for (int unsigned i = 0; i < LENGTH; i++)
                    c[i] = data[k][i];
            end
        end
    end

endmodule
